// File: rtl/ip_defs.sv
// Shared IPv4 receive constants: protocol numbers, state encoding, drop codes and
// the one's-complement adder used by the IP/UDP/ICMP checksum accumulators.
package ip_defs;

  localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [3:0]  IP_VERSION    = 4'd4;
  localparam logic [31:0] IP_BCAST      = 32'hFFFF_FFFF;
  localparam logic [4:0]  IP_MIN_HDR    = 5'd20;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam logic [2:0] DROP_NONE  = 3'd0;
  localparam logic [2:0] DROP_HDR   = 3'd1;
  localparam logic [2:0] DROP_CSUM  = 3'd2;
  localparam logic [2:0] DROP_FRAG  = 3'd3;
  localparam logic [2:0] DROP_PROTO = 3'd4;
  localparam logic [2:0] DROP_ADDR  = 3'd5;
  localparam logic [2:0] DROP_TRUNC = 3'd6;

  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-wise 16-bit one's-complement accumulator. Even-phase bytes form the high half
// of a word; o_sum already includes the word completed by the current odd byte.
module ip_csum_acc
  import ip_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_strobe,
  input  logic        i_odd,
  input  logic [7:0]  i_data,
  output logic [15:0] o_sum
);

  logic [7:0]  r_hi;
  logic [15:0] r_sum;
  logic [15:0] w_base;

  assign w_base = i_clear ? 16'd0 : r_sum;
  assign o_sum  = (i_strobe && i_odd) ? csum_add(w_base, {r_hi, i_data}) : w_base;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi  <= 8'd0;
      r_sum <= 16'd0;
    end else begin
      r_sum <= o_sum;
      if (i_strobe && !i_odd) r_hi <= i_data;
    end
  end

endmodule

// File: rtl/ip_recv.sv
// IPv4 receive layer: validates and strips the header (options included), latches the
// fields the upper layers need and forwards payload bytes of accepted packets.
module ip_recv
  import ip_defs::*;
#(
  parameter bit CHECK_CSUM             = 1'b1,
  parameter bit ACCEPT_ANY_WHEN_UNCONF = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  data_in,
  input  logic [31:0] local_ip,
  output logic        active,
  output logic [7:0]  data_out,
  output logic        is_icmp,
  output logic        is_udp,
  output logic [31:0] remote_ip,
  output logic [31:0] to_ip,
  output logic        is_broadcast,
  output logic [15:0] payload_length,
  output logic        drop,
  output logic [2:0]  drop_reason
);

  logic [1:0]  r_state;
  logic [15:0] r_byte_no;
  logic [3:0]  r_ihl;
  logic [15:0] r_total_len;
  logic        r_frag_bad;
  logic [7:0]  r_proto;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic        r_active;
  logic [7:0]  r_data;
  logic        r_is_icmp;
  logic        r_is_udp;
  logic [31:0] r_remote_ip;
  logic [31:0] r_to_ip;
  logic        r_bcast;
  logic [15:0] r_plen;
  logic        r_drop;
  logic [2:0]  r_reason;

  logic [15:0] w_hdr_len;
  logic        w_last_hdr;
  logic [31:0] w_dst_full;
  logic [15:0] w_csum;
  logic        w_csum_clear;
  logic        w_csum_strobe;
  logic        w_byte0_ok;
  logic        w_addr_ok;
  logic [2:0]  w_reason;

  assign w_hdr_len     = {10'd0, r_ihl, 2'b00};
  assign w_last_hdr    = (r_byte_no == w_hdr_len - 16'd1);
  // With a 20-byte header the last destination byte is still on data_in at decision time.
  assign w_dst_full    = (r_byte_no == 16'd19) ? {r_dst[23:0], data_in} : r_dst;
  assign w_csum_clear  = (r_state == ST_IDLE);
  assign w_csum_strobe = rx_enable && ((r_state == ST_IDLE) || (r_state == ST_HEADER));
  assign w_byte0_ok    = (data_in[7:4] == IP_VERSION) &&
                         ({data_in[3:0], 2'b00} >= {1'b0, IP_MIN_HDR});
  assign w_addr_ok     = (w_dst_full == local_ip) || (w_dst_full == IP_BCAST) ||
                         (ACCEPT_ANY_WHEN_UNCONF && (local_ip == 32'd0));

  ip_csum_acc u_csum (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_csum_clear),
    .i_strobe(w_csum_strobe),
    .i_odd   (r_byte_no[0]),
    .i_data  (data_in),
    .o_sum   (w_csum)
  );

  always_comb begin
    w_reason = DROP_NONE;
    if (r_total_len < w_hdr_len)                 w_reason = DROP_HDR;
    else if (CHECK_CSUM && (w_csum != 16'hFFFF)) w_reason = DROP_CSUM;
    else if (r_frag_bad)                         w_reason = DROP_FRAG;
    else if ((r_proto != IP_PROTO_ICMP) && (r_proto != IP_PROTO_UDP)) w_reason = DROP_PROTO;
    else if (!w_addr_ok)                         w_reason = DROP_ADDR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_byte_no   <= 16'd0;
      r_ihl       <= 4'd0;
      r_total_len <= 16'd0;
      r_frag_bad  <= 1'b0;
      r_proto     <= 8'd0;
      r_src       <= 32'd0;
      r_dst       <= 32'd0;
      r_active    <= 1'b0;
      r_data      <= 8'd0;
      r_is_icmp   <= 1'b0;
      r_is_udp    <= 1'b0;
      r_remote_ip <= 32'd0;
      r_to_ip     <= 32'd0;
      r_bcast     <= 1'b0;
      r_plen      <= 16'd0;
      r_drop      <= 1'b0;
      r_reason    <= DROP_NONE;
    end else begin
      r_drop    <= 1'b0;
      r_active  <= 1'b0;
      r_byte_no <= rx_enable ? r_byte_no + 16'd1 : 16'd0;
      if (!rx_enable) begin
        r_state <= ST_IDLE;
        if ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD)) begin
          r_drop   <= 1'b1;
          r_reason <= DROP_TRUNC;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ihl <= data_in[3:0];
            if (w_byte0_ok) begin
              r_state <= ST_HEADER;
            end else begin
              r_state  <= ST_DISCARD;
              r_drop   <= 1'b1;
              r_reason <= DROP_HDR;
            end
          end
          ST_HEADER: begin
            case (r_byte_no)
              16'd2:  r_total_len[15:8] <= data_in;
              16'd3:  r_total_len[7:0]  <= data_in;
              16'd6:  r_frag_bad <= data_in[5] | (|data_in[4:0]);
              16'd7:  r_frag_bad <= r_frag_bad | (|data_in);
              16'd9:  r_proto <= data_in;
              16'd12, 16'd13, 16'd14, 16'd15: r_src <= {r_src[23:0], data_in};
              16'd16, 16'd17, 16'd18, 16'd19: r_dst <= {r_dst[23:0], data_in};
              default: ;
            endcase
            if (w_last_hdr) begin
              if (w_reason != DROP_NONE) begin
                r_state  <= ST_DISCARD;
                r_drop   <= 1'b1;
                r_reason <= w_reason;
              end else begin
                r_is_icmp   <= (r_proto == IP_PROTO_ICMP);
                r_is_udp    <= (r_proto == IP_PROTO_UDP);
                r_remote_ip <= r_src;
                r_to_ip     <= w_dst_full;
                r_bcast     <= (w_dst_full == IP_BCAST);
                r_plen      <= r_total_len - w_hdr_len;
                // An empty payload is accepted but has nothing to forward.
                r_state     <= (r_total_len == w_hdr_len) ? ST_DISCARD : ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            r_active <= 1'b1;
            r_data   <= data_in;
            if (r_byte_no == r_total_len - 16'd1) r_state <= ST_DISCARD;
          end
          default: ;
        endcase
      end
    end
  end

  assign active         = r_active;
  assign data_out       = r_data;
  assign is_icmp        = r_is_icmp;
  assign is_udp         = r_is_udp;
  assign remote_ip      = r_remote_ip;
  assign to_ip          = r_to_ip;
  assign is_broadcast   = r_bcast;
  assign payload_length = r_plen;
  assign drop           = r_drop;
  assign drop_reason    = r_reason;

endmodule

// File: tb/tb_ip_recv.sv
// Bench for ip_recv: directed test-plan packets plus randomized frames, checked every
// cycle against a packet-level model of what the receiver must emit.
module tb_ip_recv;

  localparam logic [31:0] LIP = 32'hC0A8_010A;
  localparam logic [31:0] SRC = 32'hC0A8_0105;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_enable = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic [31:0] local_ip = LIP;

  logic        active, is_icmp, is_udp, is_broadcast, drop;
  logic [7:0]  data_out;
  logic [31:0] remote_ip, to_ip;
  logic [15:0] payload_length;
  logic [2:0]  drop_reason;

  logic        nc_active, nc_is_icmp, nc_is_udp, nc_is_broadcast, nc_drop;
  logic [7:0]  nc_data_out;
  logic [31:0] nc_remote_ip, nc_to_ip;
  logic [15:0] nc_payload_length;
  logic [2:0]  nc_drop_reason;

  always #5 clock = ~clock;

  ip_recv #(.CHECK_CSUM(1'b1), .ACCEPT_ANY_WHEN_UNCONF(1'b1)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .data_in(data_in),
    .local_ip(local_ip), .active(active), .data_out(data_out), .is_icmp(is_icmp),
    .is_udp(is_udp), .remote_ip(remote_ip), .to_ip(to_ip), .is_broadcast(is_broadcast),
    .payload_length(payload_length), .drop(drop), .drop_reason(drop_reason)
  );

  ip_recv #(.CHECK_CSUM(1'b0), .ACCEPT_ANY_WHEN_UNCONF(1'b1)) dut_nc (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .data_in(data_in),
    .local_ip(local_ip), .active(nc_active), .data_out(nc_data_out), .is_icmp(nc_is_icmp),
    .is_udp(nc_is_udp), .remote_ip(nc_remote_ip), .to_ip(nc_to_ip),
    .is_broadcast(nc_is_broadcast), .payload_length(nc_payload_length), .drop(nc_drop),
    .drop_reason(nc_drop_reason)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] pkt [0:255];

  // Expected outputs per slot; slot s = outputs after the edge that sampled frame byte s-1.
  bit         e_act  [0:255];
  logic [7:0] e_data [0:255];
  bit         e_drop [0:255];
  logic [2:0] e_rsn  [0:255];
  int win_end = 0;
  int fchk_from = 0;
  int base = 0;
  bit chk_en = 1'b0;

  logic        m_icmp = 1'b0, m_udp = 1'b0, m_bc = 1'b0;
  logic [31:0] m_rip = 32'd0, m_tip = 32'd0;
  logic [15:0] m_plen = 16'd0;

  int act_cnt, first_act, nc_act_cnt, cmp_idx;
  bit drop_seen, nc_drop_seen;
  logic [2:0] last_rsn;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ones_sum(input int hl);
    int s = 0;
    for (int i = 0; i < hl; i += 2) begin
      s += int'({pkt[i], pkt[i+1]});
      s = (s & 'hFFFF) + (s >> 16);
    end
    return s[15:0];
  endfunction

  task automatic build(input int ihl, input logic [15:0] tot, input logic [2:0] flags,
                       input logic [12:0] off, input logic [7:0] proto,
                       input logic [31:0] src, input logic [31:0] dst, input bit bad);
    logic [15:0] cs;
    for (int i = 0; i < 256; i++) pkt[i] = 8'($urandom_range(0, 255));
    pkt[0] = {4'd4, ihl[3:0]};
    pkt[1] = 8'h00;  pkt[2] = tot[15:8];  pkt[3] = tot[7:0];
    pkt[6] = {flags, off[12:8]};  pkt[7] = off[7:0];
    pkt[8] = 8'd64;  pkt[9] = proto;  pkt[10] = 8'h00;  pkt[11] = 8'h00;
    pkt[12] = src[31:24]; pkt[13] = src[23:16]; pkt[14] = src[15:8]; pkt[15] = src[7:0];
    pkt[16] = dst[31:24]; pkt[17] = dst[23:16]; pkt[18] = dst[15:8]; pkt[19] = dst[7:0];
    cs = ~ones_sum(ihl * 4);
    pkt[10] = cs[15:8];  pkt[11] = cs[7:0];
    if (bad) pkt[5] = pkt[5] ^ 8'h10;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 256; i++) begin
      e_act[i] = 0; e_data[i] = 8'd0; e_drop[i] = 0; e_rsn[i] = 3'd0;
    end
    win_end = 0; fchk_from = 0;
    m_icmp = 0; m_udp = 0; m_bc = 0; m_rip = 0; m_tip = 0; m_plen = 0;
  endtask

  task automatic compute_exp(input int n, input int g);
    bit c_act, c_drop;
    logic [7:0] c_data;
    logic [2:0] c_rsn;
    int hl, tot, rsn;
    logic [31:0] dst;
    c_act = e_act[win_end]; c_data = e_data[win_end];
    c_drop = e_drop[win_end]; c_rsn = e_rsn[win_end];
    for (int i = 0; i < 256; i++) begin
      e_act[i] = 0; e_data[i] = 8'd0; e_drop[i] = 0; e_rsn[i] = 3'd0;
    end
    e_act[0] = c_act; e_data[0] = c_data; e_drop[0] = c_drop; e_rsn[0] = c_rsn;
    win_end = n + g;
    fchk_from = 0;
    hl = 4 * int'(pkt[0][3:0]);
    if (pkt[0][7:4] != 4'd4 || hl < 20) begin
      e_drop[1] = 1; e_rsn[1] = 3'd1;
    end else if (n < hl) begin
      e_drop[n+1] = 1; e_rsn[n+1] = 3'd6;
    end else begin
      tot = int'({pkt[2], pkt[3]});
      dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
      if (tot < hl) rsn = 1;
      else if (ones_sum(hl) != 16'hFFFF) rsn = 2;
      else if (pkt[6][5] || {pkt[6][4:0], pkt[7]} != 13'd0) rsn = 3;
      else if (pkt[9] != 8'd1 && pkt[9] != 8'd17) rsn = 4;
      else if (!(dst == local_ip || dst == 32'hFFFF_FFFF || local_ip == 32'd0)) rsn = 5;
      else rsn = 0;
      if (rsn != 0) begin
        e_drop[hl] = 1; e_rsn[hl] = rsn[2:0];
      end else begin
        m_icmp = (pkt[9] == 8'd1);  m_udp = (pkt[9] == 8'd17);
        m_rip = {pkt[12], pkt[13], pkt[14], pkt[15]};
        m_tip = dst;  m_bc = (dst == 32'hFFFF_FFFF);  m_plen = 16'(tot - hl);
        fchk_from = hl;
        for (int k = hl; k < tot && k < n; k++) begin
          e_act[k+1] = 1; e_data[k+1] = pkt[k];
        end
        if (n < tot) begin
          e_drop[n+1] = 1; e_rsn[n+1] = 3'd6;
        end
      end
    end
  endtask

  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic run_pkt(input int n, input int g);
    compute_exp(n, g);
    act_cnt = 0; first_act = -1; nc_act_cnt = 0;
    drop_seen = 0; nc_drop_seen = 0; last_rsn = 3'd0;
    base = cyc;
    chk_en = 1;
    for (int t = 0; t < n + g; t++) begin
      rx_enable = (t < n);
      data_in   = (t < n) ? pkt[t] : 8'h00;
      @(posedge clock); #1;
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp_idx = cyc - base;
      if (cmp_idx >= 0 && cmp_idx <= win_end) begin
        chk($sformatf("active@%0d", cmp_idx), {31'd0, active}, {31'd0, e_act[cmp_idx]});
        chk($sformatf("drop@%0d", cmp_idx), {31'd0, drop}, {31'd0, e_drop[cmp_idx]});
        if (e_act[cmp_idx])
          chk($sformatf("data_out@%0d", cmp_idx), {24'd0, data_out}, {24'd0, e_data[cmp_idx]});
        if (e_drop[cmp_idx])
          chk($sformatf("reason@%0d", cmp_idx), {29'd0, drop_reason}, {29'd0, e_rsn[cmp_idx]});
        if (cmp_idx >= fchk_from) begin
          chk($sformatf("is_udp@%0d", cmp_idx), {31'd0, is_udp}, {31'd0, m_udp});
          chk($sformatf("is_icmp@%0d", cmp_idx), {31'd0, is_icmp}, {31'd0, m_icmp});
          chk($sformatf("remote_ip@%0d", cmp_idx), remote_ip, m_rip);
          chk($sformatf("to_ip@%0d", cmp_idx), to_ip, m_tip);
          chk($sformatf("bcast@%0d", cmp_idx), {31'd0, is_broadcast}, {31'd0, m_bc});
          chk($sformatf("plen@%0d", cmp_idx), {16'd0, payload_length}, {16'd0, m_plen});
        end
        if (active) begin
          act_cnt++;
          if (first_act < 0) first_act = cmp_idx;
        end
        if (drop) begin
          drop_seen = 1; last_rsn = drop_reason;
        end
        if (nc_active) nc_act_cnt++;
        if (nc_drop) nc_drop_seen = 1;
      end
    end
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    chk("rst_plen", {16'd0, payload_length}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, LIP, 0);
    run_pkt(36, 3);
    chk("udp_first_act", first_act, 21);
    chk("udp_act_cnt", act_cnt, 16);
    chk("udp_plen", {16'd0, payload_length}, 32'd16);
    chk("udp_is_udp", {31'd0, is_udp}, 32'd1);
    chk("udp_remote_ip", remote_ip, SRC);
    chk("udp_no_drop", {31'd0, drop_seen}, 32'd0);

    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, LIP, 1);
    run_pkt(36, 3);
    chk("csum_reason", {29'd0, last_rsn}, 32'd2);
    chk("csum_no_active", act_cnt, 0);
    chk("nocheck_act_cnt", nc_act_cnt, 16);
    chk("nocheck_no_drop", {31'd0, nc_drop_seen}, 32'd0);

    build(6, 16'd40, 3'b000, 13'd0, 8'd1, SRC, LIP, 0);
    run_pkt(40, 3);
    chk("opt_first_act", first_act, 25);
    chk("opt_is_icmp", {31'd0, is_icmp}, 32'd1);
    chk("opt_plen", {16'd0, payload_length}, 32'd16);

    build(5, 16'd36, 3'b001, 13'd0, 8'd17, SRC, LIP, 0);
    run_pkt(36, 3);
    chk("frag_reason", {29'd0, last_rsn}, 32'd3);
    build(5, 16'd36, 3'b000, 13'd0, 8'd6, SRC, LIP, 0);
    run_pkt(36, 3);
    chk("proto_reason", {29'd0, last_rsn}, 32'd4);
    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, 32'h0A00_0063, 0);
    run_pkt(36, 3);
    chk("addr_reason", {29'd0, last_rsn}, 32'd5);
    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, 32'hFFFF_FFFF, 0);
    run_pkt(36, 3);
    chk("bcast_flag", {31'd0, is_broadcast}, 32'd1);
    chk("bcast_act_cnt", act_cnt, 16);

    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, LIP, 0);
    run_pkt(30, 2);
    chk("trunc_reason", {29'd0, last_rsn}, 32'd6);
    chk("trunc_act_cnt", act_cnt, 10);
    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, LIP, 0);
    run_pkt(54, 3);
    chk("pad_act_cnt", act_cnt, 16);
    chk("pad_no_drop", {31'd0, drop_seen}, 32'd0);

    // Asynchronous reset in the middle of a payload.
    chk_en = 0;
    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, LIP, 0);
    for (int t = 0; t < 26; t++) begin
      rx_enable = 1'b1; data_in = pkt[t];
      @(posedge clock); #1;
    end
    chk("pre_rst_active", {31'd0, active}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_udp", {31'd0, is_udp}, 32'd0);
    chk("mid_rst_rip", remote_ip, 32'd0);
    chk("mid_rst_tip", to_ip, 32'd0);
    chk("mid_rst_plen", {16'd0, payload_length}, 32'd0);
    rx_enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    reset_model();
    @(posedge clock); #1;
    build(5, 16'd36, 3'b000, 13'd0, 8'd17, SRC, LIP, 0);
    run_pkt(36, 3);
    chk("post_rst_act_cnt", act_cnt, 16);

    for (int p = 0; p < 60; p++) begin
      int ihl, hl, tot, n, mx, sel;
      logic [31:0] dst;
      logic [7:0] proto;
      logic [2:0] flags;
      logic [12:0] off;
      local_ip = ($urandom_range(0, 5) == 0) ? 32'd0 : LIP;
      ihl = $urandom_range(5, 7);
      hl = ihl * 4;
      tot = ($urandom_range(0, 9) == 0) ? $urandom_range(0, hl - 1) : hl + $urandom_range(0, 20);
      sel = $urandom_range(0, 9);
      proto = (sel < 5) ? 8'd17 : (sel < 8) ? 8'd1 : 8'd6;
      sel = $urandom_range(0, 9);
      dst = (sel < 6) ? LIP : (sel < 8) ? 32'hFFFF_FFFF : $urandom;
      sel = $urandom_range(0, 9);
      flags = (sel == 0) ? 3'b001 : (sel == 1) ? 3'b010 : 3'b000;
      off = (sel == 2) ? 13'($urandom_range(1, 100)) : 13'd0;
      build(ihl, 16'(tot), flags, off, proto, $urandom, dst, $urandom_range(0, 6) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0) pkt[0] = 8'h65;
      else if (sel == 1) pkt[0] = 8'h43;
      mx = (tot > hl) ? tot : hl;
      n = ($urandom_range(0, 6) == 0) ? $urandom_range(1, mx - 1) : mx + $urandom_range(0, 18);
      run_pkt(n, $urandom_range(1, 3));
    end
    @(negedge clock);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
